mmio_par_channels: RTL

- Parametrised successor to the single parallel-output MMIO decoder.
- Sits between the CPU memory port and physical RAM.
  - Addresses with ram_addr[15]=0 pass through to RAM.
  - Addresses with ram_addr[15]=1 decode into CHANNELS independent parallel output channels.
- Each channel has a DEPTH-entry transmit FIFO drained by a valid/ack handshake, a level signal bit, and a status register with a sticky overflow flag.

---
 rtl/mmio_pkg.sv | 22 ++
 rtl/par_fifo.sv | 59 +++++
 rtl/mmio_par_channels.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// Shared constants for the parallel-output MMIO channel block: address
// decode fields, register offsets and STATUS bit positions.
package mmio_pkg;

  // Address bit that steers an access away from RAM into MMIO space.
  localparam int unsigned MMIO_SEL_BIT = 15;
  // Value of ram_addr[11:8] that selects the parallel channel page.
  localparam logic [3:0]  PAR_PAGE     = 4'h1;

  // Per-channel register offsets (ram_addr[3:0]).
  localparam logic [3:0]  REG_DATA     = 4'd0;
  localparam logic [3:0]  REG_SIGNAL   = 4'd1;
  localparam logic [3:0]  REG_STATUS   = 4'd2;

  // STATUS register bit positions.
  localparam int unsigned ST_EMPTY     = 0;
  localparam int unsigned ST_FULL      = 1;
  localparam int unsigned ST_VALID     = 2;
  localparam int unsigned ST_OVF       = 3;
  localparam int unsigned ST_COUNT_LSB = 8;

endpackage

// File: rtl/par_fifo.sv
// Transmit FIFO for one parallel output channel.
// Ports: clk, rst (async, active-high); push/push_data write side;
// pop drains the head (ignored while empty); head is the current front
// entry (0 when empty); count/empty/full report occupancy; push_ok flags
// that the push in this cycle is accepted.
module par_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full,
  output logic                         push_ok
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot the push needs, even when full.
  assign push_ok = push & (~full | do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  // Storage is not reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_par_channels.sv
// MMIO decoder between the CPU memory port and RAM, exposing CHANNELS
// independent parallel output channels, each with a transmit FIFO, a level
// signal bit and a STATUS register carrying a sticky overflow flag.
// Ports: clk, rst (async, active-high); CPU side ram_addr/ram_write/ram_op
// and combinational ram_read; RAM side phy_ram_*; channel side par_data,
// par_valid, par_ack and par_signal (channel c at bit/field c).
module mmio_par_channels
  import mmio_pkg::*;
#(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [15:0]               ram_addr,
  input  logic [15:0]               ram_write,
  input  logic                      ram_op,
  output logic [15:0]               ram_read,
  output logic [15:0]               phy_ram_addr,
  output logic [15:0]               phy_ram_write,
  output logic                      phy_ram_op,
  input  logic [15:0]               phy_ram_read,
  output logic [CHANNELS*WIDTH-1:0] par_data,
  output logic [CHANNELS-1:0]       par_valid,
  input  logic [CHANNELS-1:0]       par_ack,
  output logic [CHANNELS-1:0]       par_signal
);

  localparam int unsigned CW = $clog2(DEPTH+1);

  logic        mmio_sel;
  logic        page_hit;
  logic [3:0]  ch_sel;
  logic [3:0]  reg_sel;
  logic [15:0] mmio_read;
  logic [15:0] ch_rd [CHANNELS];
  logic        unused_addr;

  assign mmio_sel    = ram_addr[MMIO_SEL_BIT];
  assign page_hit    = mmio_sel && (ram_addr[11:8] == PAR_PAGE);
  assign ch_sel      = ram_addr[7:4];
  assign reg_sel     = ram_addr[3:0];
  assign unused_addr = &{1'b0, ram_addr[14:12]};

  // RAM pass-through; MMIO accesses never reach RAM.
  assign phy_ram_addr  = mmio_sel ? 16'h0000 : ram_addr;
  assign phy_ram_write = ram_write;
  assign phy_ram_op    = ram_op & ~mmio_sel;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic             ch_hit;
    logic             push;
    logic             push_ok;
    logic             empty;
    logic             full;
    logic             ovf;
    logic             sig;
    logic [WIDTH-1:0] head;
    logic [CW-1:0]    count;
    logic [15:0]      status;

    // Unimplemented channel indices never match, so they read 0 and drop writes.
    assign ch_hit = page_hit && (ch_sel == 4'(c));
    assign push   = ch_hit && ram_op && (reg_sel == REG_DATA);

    par_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (ram_write[WIDTH-1:0]),
      .pop       (par_ack[c]),
      .head      (head),
      .count     (count),
      .empty     (empty),
      .full      (full),
      .push_ok   (push_ok)
    );

    // Overflow set wins over a same-cycle clear; signal bit is a plain register.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ovf <= 1'b0;
        sig <= 1'b0;
      end else begin
        if (push && !push_ok) begin
          ovf <= 1'b1;
        end else if (ch_hit && ram_op && (reg_sel == REG_STATUS) && ram_write[ST_OVF]) begin
          ovf <= 1'b0;
        end
        if (ch_hit && ram_op && (reg_sel == REG_SIGNAL)) sig <= ram_write[0];
      end
    end

    always_comb begin
      status                       = '0;
      status[ST_EMPTY]             = empty;
      status[ST_FULL]              = full;
      status[ST_VALID]             = ~empty;
      status[ST_OVF]               = ovf;
      status[ST_COUNT_LSB +: 8]    = 8'(count);
    end

    assign ch_rd[c] = !ch_hit                  ? 16'h0000 :
                      (reg_sel == REG_DATA)    ? 16'(head) :
                      (reg_sel == REG_SIGNAL)  ? {16{sig}} :
                      (reg_sel == REG_STATUS)  ? status :
                                                 16'h0000;

    assign par_data[c*WIDTH +: WIDTH] = head;
    assign par_valid[c]               = ~empty;
    assign par_signal[c]              = sig;
  end

  // At most one channel decodes per access, so an OR merge is a mux.
  always_comb begin
    mmio_read = '0;
    for (int c = 0; c < CHANNELS; c++) mmio_read = mmio_read | ch_rd[c];
  end

  assign ram_read = mmio_sel ? mmio_read : phy_ram_read;

endmodule
